// File: rtl/pf_lanectrl_pause_gen.sv
// Initiator side of the lane-controller clock-pause protocol: wraps each delay-code update in a
// pause window long enough to cover the lane pause synchronizer, then acknowledges after a guard.
module pf_lanectrl_pause_gen #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned GUARD_CYC = 4,
  parameter int unsigned CODE_W    = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PAUSE_EN,
  input  logic              UPDATE_REQ,
  input  logic [CODE_W-1:0] UPDATE_CODE_IN,
  output logic              HS_IO_CLK_PAUSE,
  output logic              UPDATE_STROBE,
  output logic [CODE_W-1:0] UPDATE_CODE_OUT,
  output logic              BUSY,
  output logic              UPDATE_ACK,
  output logic [7:0]        UPDATE_CNT
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StGuard,
    StAck
  } state_e;

  localparam logic [CNT_W-1:0] SetupLoad = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLoad  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GuardLoad = CNT_W'(GUARD_CYC - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              armed_q;
  logic              mode_q;
  logic              pause_q;
  logic              strobe_q;
  logic              busy_q;
  logic              ack_q;
  logic [CODE_W-1:0] code_q;
  logic [7:0]        upd_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      mode_q    <= 1'b0;
      pause_q   <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      code_q    <= '0;
      upd_cnt_q <= '0;
    end else begin
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
      // Re-arm only after the requester has visibly dropped REQ, so a held REQ cannot retrigger.
      if (!UPDATE_REQ) begin
        armed_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (UPDATE_REQ && armed_q) begin
            armed_q <= 1'b0;
            code_q  <= UPDATE_CODE_IN;
            mode_q  <= PAUSE_EN;
            busy_q  <= 1'b1;
            if (PAUSE_EN) begin
              state_q <= StSetup;
              cnt_q   <= SetupLoad;
              pause_q <= 1'b1;
            end else begin
              state_q  <= StStrobe;
              cnt_q    <= '0;
              strobe_q <= 1'b1;
            end
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            state_q  <= StStrobe;
            cnt_q    <= '0;
            strobe_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StStrobe: begin
          if (mode_q) begin
            state_q <= StHold;
            cnt_q   <= HoldLoad;
          end else begin
            state_q   <= StAck;
            cnt_q     <= '0;
            ack_q     <= 1'b1;
            upd_cnt_q <= upd_cnt_q + 8'd1;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_q <= StGuard;
            cnt_q   <= GuardLoad;
            pause_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StGuard: begin
          if (cnt_q == '0) begin
            state_q   <= StAck;
            cnt_q     <= '0;
            ack_q     <= 1'b1;
            upd_cnt_q <= upd_cnt_q + 8'd1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StAck: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          pause_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign HS_IO_CLK_PAUSE = pause_q;
  assign UPDATE_STROBE   = strobe_q;
  assign UPDATE_CODE_OUT = code_q;
  assign BUSY            = busy_q;
  assign UPDATE_ACK      = ack_q;
  assign UPDATE_CNT      = upd_cnt_q;

endmodule

// File: doc/pf_lanectrl_pause_gen.md
Name: pf_lanectrl_pause_gen

Overview:
- Initiator side of the lane-controller clock-pause protocol.
- Accepts delay-code update requests from training/calibration logic over a REQ/ACK handshake.
- Raises HS_IO_CLK_PAUSE, which feeds the lane pause synchronizer, and holds it long enough to cover that synchronizer's pipeline.
- Issues a one-cycle update strobe with the code inside the pause window, releases pause, waits a guard interval, then acknowledges.

Parameters:
- SETUP_CYC, 2: pause-high cycles before UPDATE_STROBE. Range 1..2^CNT_W-1.
- HOLD_CYC, 2: pause-high cycles after UPDATE_STROBE. Range 1..2^CNT_W-1.
- GUARD_CYC, 4: pause-low cycles between pause release and ACK. Range 1..2^CNT_W-1.
- CODE_W, 8: width of the update code.
- CNT_W, 4: width of the internal phase counter.

Ports:
- CLK  in  1  lane fabric clock.
- RESET  in  1  synchronous, active-high reset.
- PAUSE_EN  in  1  1 = wrap updates in a pause window; 0 = bypass the pause. Sampled only at request accept.
- UPDATE_REQ  in  1  level request; requester holds it until ACK.
- UPDATE_CODE_IN  in  CODE_W  code to apply; sampled at request accept.
- HS_IO_CLK_PAUSE  out  1  pause request to the lane pause synchronizer.
- UPDATE_STROBE  out  1  one-cycle load strobe for the lane delay logic.
- UPDATE_CODE_OUT  out  CODE_W  code latched at accept; stable from accept until the next accept.
- BUSY  out  1  high in every state except IDLE.
- UPDATE_ACK  out  1  one-cycle completion pulse.
- UPDATE_CNT  out  8  count of completed updates; wraps 255 -> 0.

Behaviour:
- All outputs are registered.
- Reset (any cycle, including mid-sequence):
  - all outputs go to 0 on the next edge; state = IDLE; armed = 1.
  - an in-flight update is abandoned: no ACK, no strobe, HS_IO_CLK_PAUSE drops immediately.
- States: IDLE, SETUP, STROBE, HOLD, GUARD, ACK.
- Arming:
  - an accept requires UPDATE_REQ=1, state IDLE and armed=1.
  - armed clears at accept and sets in any cycle UPDATE_REQ is sampled 0.
  - consequence: a REQ still held after ACK does not retrigger.
- Accept at edge k (PAUSE_EN=1):
  - latch code and mode.
  - k+1..k+SETUP: SETUP, HS_IO_CLK_PAUSE=1.
  - next cycle: STROBE, HS_IO_CLK_PAUSE=1, UPDATE_STROBE=1.
  - next HOLD_CYC cycles: HOLD, HS_IO_CLK_PAUSE=1.
  - next GUARD_CYC cycles: GUARD, HS_IO_CLK_PAUSE=0.
  - next cycle: ACK, UPDATE_ACK=1, UPDATE_CNT increments.
  - then IDLE.
- Pause width is exactly SETUP_CYC+1+HOLD_CYC cycles and contiguous. The strobe never coincides with the first or last pause cycle.
- Bypass (PAUSE_EN=0 at accept):
  - IDLE -> STROBE at k+1 (UPDATE_STROBE=1, HS_IO_CLK_PAUSE=0) -> ACK at k+2 -> IDLE.
  - HS_IO_CLK_PAUSE stays 0 throughout.
- A single CNT_W counter loads (phase length - 1) on state entry and decrements; the state advances when it reaches 0.
- BUSY rises with the first post-accept state and falls in the cycle after ACK.
- UPDATE_REQ dropping mid-sequence does not abort; the sequence completes and ACK still pulses.
- PAUSE_EN and UPDATE_CODE_IN changes after accept are ignored.
- The earliest possible back-to-back accept is the cycle after ACK, provided REQ was low for at least one cycle after the previous accept.
- UPDATE_CNT is unaffected by bypass mode: both modes increment it.

Test Plan:
- Defaults, PAUSE_EN=1, code 0x5A, REQ rises at edge 10 ->
  - HS_IO_CLK_PAUSE=1 on cycles 11-15.
  - UPDATE_STROBE=1 only on cycle 13, with UPDATE_CODE_OUT=0x5A.
  - UPDATE_ACK=1 on cycle 20; BUSY on 11-20; UPDATE_CNT 0->1.
- REQ held high through and after ACK -> no second sequence; then REQ low 1 cycle, high again -> new accept, pause on the following cycle.
- PAUSE_EN=0, code 0x33 -> STROBE at k+1 with HS_IO_CLK_PAUSE never high; ACK at k+2.
- RESET asserted on the strobe cycle -> next edge: HS_IO_CLK_PAUSE, BUSY, UPDATE_STROBE, UPDATE_CODE_OUT all 0; no ACK; UPDATE_CNT=0; a fresh REQ is accepted normally.
- SETUP_CYC=1, HOLD_CYC=1, GUARD_CYC=1 -> pause width exactly 3 cycles, strobe in the middle cycle, ACK 2 cycles after pause falls.
- 256 back-to-back updates -> UPDATE_CNT wraps to 0; the pause width is identical on every update.
